core_scheduler: RTL and testbench

Run-level sequencer for the multi-core matrix-multiplication processor. On a start request it launches a selected subset of up to four cores by driving their 2-bit `status` inputs to run (2'b01) and collects each core's `end_process` flag. It stops each core as it finishes, and reports completion, elapsed cycles and an optional timeout. It sits between the host/testbench and the `processor` status inputs, replacing static tie-offs of `on_status`/`off_status`.

---
 rtl/core_scheduler_if.sv | 30 +++
 rtl/core_scheduler.sv | 164 ++++++++++++++++
 tb/tb_core_scheduler.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/core_scheduler_if.sv
// Host/core-side signal bundle for core_scheduler.
// master: host/testbench side (drives start, abort, core_mask and the core end_process flags).
// slave : the scheduler itself.
interface core_scheduler_if;
   localparam int unsigned NCORE = 4;
   localparam int unsigned CW    = 16;

   logic              start;
   logic              abort;
   logic [NCORE-1:0]  core_mask;
   logic [NCORE-1:0]  end_process;
   logic [1:0]        status0;
   logic [1:0]        status1;
   logic [1:0]        status2;
   logic [1:0]        status3;
   logic              busy;
   logic              done;
   logic [CW-1:0]     cycles;
   logic [NCORE-1:0]  timed_out;

   modport master (
      output start, abort, core_mask, end_process,
      input  status0, status1, status2, status3, busy, done, cycles, timed_out
   );

   modport slave (
      input  start, abort, core_mask, end_process,
      output status0, status1, status2, status3, busy, done, cycles, timed_out
   );
endinterface

// File: rtl/core_scheduler.sv
// Run-level sequencer for up to four matrix-multiplication cores.
// Launches the cores selected by core_mask, retires each one as its end_process
// flag is seen, and reports done / elapsed RUN cycles.
// Optional feature: define CORE_TIMEOUT_EN to end a run after TIMEOUT_CYCLES RUN
// cycles and report the still-pending cores in timed_out.
module core_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic            clk,
   input  logic            reset,
   core_scheduler_if.slave bus
);
   localparam int unsigned NCORE = 4;
   localparam int unsigned CW    = 16;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_RUN    = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // Reject timeout limits that cannot be represented by the cycle counter.
   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range
      $error("core_scheduler: TIMEOUT_CYCLES must be in [2, 65535]");
   end

`ifdef CORE_TIMEOUT_EN
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

   logic [1:0]       state, state_nxt;
   logic [NCORE-1:0] run, run_nxt;
   logic [NCORE-1:0] active, active_nxt;
   logic [NCORE-1:0] pending, pending_nxt;
   logic [NCORE-1:0] timed_out, timed_out_nxt;
   logic             busy, busy_nxt;
   logic             done, done_nxt;
   logic [CW-1:0]    cycles, cycles_nxt;

   logic [NCORE-1:0] retire_c;
   logic [NCORE-1:0] left_c;
   logic [CW-1:0]    cycles_inc_c;

   // State and output registers; reset drops every core to off immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         run       <= '0;
         active    <= '0;
         pending   <= '0;
         timed_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cycles    <= '0;
      end else begin
         state     <= state_nxt;
         run       <= run_nxt;
         active    <= active_nxt;
         pending   <= pending_nxt;
         timed_out <= timed_out_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         cycles    <= cycles_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt     = state;
      run_nxt       = run;
      active_nxt    = active;
      pending_nxt   = pending;
      timed_out_nxt = timed_out;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      cycles_nxt    = cycles;

      // Only launched, still-pending cores can retire; other flags are noise.
      retire_c     = pending & active & bus.end_process;
      left_c       = pending & ~bus.end_process;
      cycles_inc_c = (cycles == {CW{1'b1}}) ? cycles : cycles + CW'(1);

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               cycles_nxt    = '0;
               timed_out_nxt = '0;
               if (bus.core_mask != '0) begin
                  active_nxt  = bus.core_mask;
                  pending_nxt = bus.core_mask;
                  run_nxt     = bus.core_mask;
                  busy_nxt    = 1'b1;
                  state_nxt   = S_LAUNCH;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = S_DONE;
               end
            end
         end

         S_LAUNCH: begin
            // end_process is not looked at here so stale flags never retire a core.
            if (bus.abort) begin
               run_nxt     = '0;
               pending_nxt = '0;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = S_DONE;
            end else begin
               state_nxt = S_RUN;
            end
         end

         S_RUN: begin
            cycles_nxt = cycles_inc_c;
            if (bus.abort) begin
               run_nxt     = '0;
               pending_nxt = '0;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = S_DONE;
            end else if (left_c == '0) begin
               run_nxt     = '0;
               pending_nxt = '0;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = S_DONE;
            end
`ifdef CORE_TIMEOUT_EN
            else if (cycles == TIMEOUT_LAST) begin
               timed_out_nxt = left_c;
               run_nxt       = '0;
               pending_nxt   = '0;
               busy_nxt      = 1'b0;
               done_nxt      = 1'b1;
               state_nxt     = S_DONE;
            end
`endif
            else begin
               run_nxt     = run & ~retire_c;
               pending_nxt = pending & ~retire_c;
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Drive the bundle from the registered state.
   assign bus.status0   = {1'b0, run[0]};
   assign bus.status1   = {1'b0, run[1]};
   assign bus.status2   = {1'b0, run[2]};
   assign bus.status3   = {1'b0, run[3]};
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.cycles    = cycles;
   assign bus.timed_out = timed_out;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: directed scenarios plus randomized runs,
// each checked against a run-level model (finish times, abort point, timeout).
module tb_core_scheduler;
   localparam int unsigned TO    = 50;
   localparam int          NEVER = 1000000;
`ifdef CORE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;

   core_scheduler_if bus ();

   core_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int fin [4];
   int abort_at;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] expand(input logic [3:0] r);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[2*i] = r[i];
      return v;
   endfunction

   function automatic logic [7:0] status_vec();
      return {bus.status3, bus.status2, bus.status1, bus.status0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] exp_run, input logic exp_busy,
                            input logic exp_done, input int exp_cycles, input logic [3:0] exp_to);
      check({tag, ".status"},    32'(status_vec()), 32'(expand(exp_run)));
      check({tag, ".busy"},      32'(bus.busy),     32'(exp_busy));
      check({tag, ".done"},      32'(bus.done),     32'(exp_done));
      check({tag, ".cycles"},    32'(bus.cycles),   32'(exp_cycles));
      check({tag, ".timed_out"}, 32'(bus.timed_out), 32'(exp_to));
   endtask

   // One complete run: the model derives end cycle, per-core stop points and timeout flags.
   task automatic run_case(input string tag, input logic [3:0] mask);
      int         maxf, endc;
      logic [3:0] exp_to, exp_run, ep;

      maxf = 0;
      for (int i = 0; i < 4; i++) if (mask[i] && fin[i] > maxf) maxf = fin[i];
      endc = maxf;
      if (abort_at < endc) endc = abort_at;
      if (TO_EN && int'(TO) < endc) endc = int'(TO);
      exp_to = '0;
      if (TO_EN && endc == int'(TO) && abort_at > int'(TO) && maxf > int'(TO))
         for (int i = 0; i < 4; i++) exp_to[i] = mask[i] && (fin[i] > int'(TO));

      bus.start       = 1'b1;
      bus.core_mask   = mask;
      bus.abort       = 1'($urandom % 2);
      bus.end_process = 4'($urandom);
      tick();
      check_all({tag, ".start"}, mask, 1'b1, 1'b0, 0, 4'b0);

      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.end_process = 4'($urandom);
      tick();
      check_all({tag, ".launch"}, mask, 1'b1, 1'b0, 0, 4'b0);

      for (int k = 1; k <= endc; k++) begin
         for (int i = 0; i < 4; i++)
            ep[i] = mask[i] ? (k == fin[i]) : 1'($urandom % 2);
         bus.end_process = ep;
         bus.abort       = (k == abort_at);
         bus.start       = 1'($urandom % 2);
         bus.core_mask   = 4'($urandom);
         tick();
         for (int i = 0; i < 4; i++) exp_run[i] = mask[i] && (k < fin[i]) && (k < endc);
         check_all($sformatf("%s.run%0d", tag, k), exp_run, k < endc, k == endc, k,
                   (k == endc) ? exp_to : 4'b0);
      end

      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.end_process = '0;
      tick();
      check_all({tag, ".after"}, 4'b0, 1'b0, 1'b0, endc, exp_to);
   endtask

   initial begin
      int maxf;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.core_mask   = '0;
      bus.end_process = '0;

      #1 reset = 1'b1;
      #1;
      check_all("reset", 4'b0, 1'b0, 1'b0, 0, 4'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Three-core run finishing together at RUN cycle 20.
      fin = '{20, 20, 20, NEVER};
      abort_at = NEVER;
      run_case("three", 4'b0111);

      // Staggered finish, core 2 not launched.
      fin = '{5, 9, NEVER, 9};
      abort_at = NEVER;
      run_case("stagger", 4'b1011);

      // Zero mask goes straight to done without going busy.
      bus.start     = 1'b1;
      bus.core_mask = 4'b0000;
      tick();
      check_all("zero.start", 4'b0, 1'b0, 1'b1, 0, 4'b0);
      bus.start = 1'b0;
      tick();
      check_all("zero.after", 4'b0, 1'b0, 1'b0, 0, 4'b0);

      // Abort at RUN cycle 7.
      fin = '{NEVER, NEVER, NEVER, NEVER};
      abort_at = 7;
      run_case("abort", 4'b1111);

      // Timeout scenario; without the timeout feature the run is still busy at 200 cycles.
      fin = '{10, NEVER, NEVER, NEVER};
      abort_at = TO_EN ? NEVER : 201;
      run_case("timeout", 4'b0011);

      // Randomized runs.
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 4; i++)
            fin[i] = ($urandom % 5 == 0) ? NEVER : int'($urandom_range(1, 60));
         abort_at = ($urandom % 4 == 0) ? int'($urandom_range(1, 60)) : NEVER;
         maxf = 0;
         for (int i = 0; i < 4; i++) if (fin[i] > maxf) maxf = fin[i];
         if (!TO_EN && maxf >= NEVER && abort_at >= NEVER) abort_at = int'($urandom_range(1, 60));
         run_case($sformatf("rand%0d", r), 4'($urandom_range(1, 15)));
      end

      // Asynchronous reset in the middle of a run.
      bus.start     = 1'b1;
      bus.core_mask = 4'b1111;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      check("mid.busy_before", 32'(bus.busy), 32'(1));
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_all("mid.reset", 4'b0, 1'b0, 1'b0, 0, 4'b0);
      tick();
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_all($sformatf("mid.post%0d", k), 4'b0, 1'b0, 1'b0, 0, 4'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
